// File: rtl/ecc_decode_pipe.sv
// Pipelined SECDED Hamming decoder with saturating error counters.
// Build option: define ECC_DECODE_PIPE_BYPASS_EN to drop the input stage (1-cycle latency).
`timescale 1ns/1ps

package ecc_pkg;

  // Number of Hamming parity bits r: smallest r with 2^r >= data_width + r + 1.
  function automatic int unsigned get_cw_width(int unsigned data_width);
    int unsigned r;
    logic        found;
    r     = 0;
    found = 1'b0;
    for (int unsigned k = 1; k < 31; k++) begin
      if (!found && ((32'd1 << k) >= (data_width + k + 32'd1))) begin
        r     = k;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Hamming position of data bit idx: the idx-th position that is not a power of two.
  function automatic int unsigned data_pos(int unsigned idx);
    int unsigned cnt;
    int unsigned pos_found;
    logic        found;
    cnt       = 0;
    pos_found = 0;
    found     = 1'b0;
    for (int unsigned pos = 3; pos < idx + 64; pos++) begin
      if (!found && ((pos & (pos - 32'd1)) != 0)) begin
        if (cnt == idx) begin
          pos_found = pos;
          found     = 1'b1;
        end
        cnt++;
      end
    end
    return pos_found;
  endfunction

endpackage

module ecc_decode_pipe #(
  parameter  int unsigned DataWidth = 64,
  parameter  int unsigned CntWidth  = 16,
  localparam int unsigned ParWidth  = ecc_pkg::get_cw_width(DataWidth),
  localparam int unsigned CwWidth   = DataWidth + ParWidth + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [CwWidth-1:0]   in_cw_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic [ParWidth-1:0]  out_syndrome_o,
  output logic                 out_single_err_o,
  output logic                 out_double_err_o,
  input  logic                 clear_cnt_i,
  output logic [CntWidth-1:0]  corr_cnt_o,
  output logic [CntWidth-1:0]  uncorr_cnt_o
);

  localparam int unsigned NumPos = DataWidth + ParWidth;

  logic                 s2_can_take_c;
  logic                 src_valid_c;
  logic [CwWidth-1:0]   dec_cw_c;
  logic [ParWidth-1:0]  syn_c;
  logic                 par_c;
  logic                 in_range_c;
  logic                 single_c;
  logic                 double_c;
  logic [DataWidth-1:0] data_c;
  logic                 out_hs_c;

  assign s2_can_take_c = !out_valid_o | out_ready_i;
  assign out_hs_c      = out_valid_o & out_ready_i;

`ifdef ECC_DECODE_PIPE_BYPASS_EN
  assign dec_cw_c    = in_cw_i;
  assign src_valid_c = in_valid_i;
  assign in_ready_o  = s2_can_take_c;
`else
  logic               s1_valid;
  logic [CwWidth-1:0] s1_cw;

  // Input stage: loads whenever empty or draining into the output stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
    end else if (in_ready_o) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) s1_cw <= in_cw_i;
    end
  end

  assign dec_cw_c    = s1_cw;
  assign src_valid_c = s1_valid;
  assign in_ready_o  = !s1_valid | s2_can_take_c;
`endif

  // Syndrome bit k collects every position whose index has bit k set.
  always_comb begin
    syn_c = '0;
    for (int unsigned i = 1; i <= NumPos; i++) begin
      for (int unsigned k = 0; k < ParWidth; k++) begin
        if (((i >> k) & 32'd1) != 0) syn_c[k] = syn_c[k] ^ dec_cw_c[i];
      end
    end
  end

  assign par_c      = ^dec_cw_c;
  assign in_range_c = 32'(syn_c) <= NumPos;
  assign single_c   = par_c & in_range_c;
  assign double_c   = par_c ? !in_range_c : (syn_c != '0);

  // A data bit flips only when a single error points exactly at its position.
  for (genvar d = 0; d < DataWidth; d++) begin : g_data
    localparam int unsigned Pos = ecc_pkg::data_pos(d);
    assign data_c[d] = dec_cw_c[Pos] ^ (par_c && (syn_c == ParWidth'(Pos)));
  end

  // Output stage: holds its contents while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o      <= 1'b0;
      out_data_o       <= '0;
      out_syndrome_o   <= '0;
      out_single_err_o <= 1'b0;
      out_double_err_o <= 1'b0;
    end else if (s2_can_take_c) begin
      out_valid_o <= src_valid_c;
      if (src_valid_c) begin
        out_data_o       <= data_c;
        out_syndrome_o   <= syn_c;
        out_single_err_o <= single_c;
        out_double_err_o <= double_c;
      end
    end
  end

  // Saturating statistics; clear wins over a simultaneous increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      corr_cnt_o   <= '0;
      uncorr_cnt_o <= '0;
    end else if (clear_cnt_i) begin
      corr_cnt_o   <= '0;
      uncorr_cnt_o <= '0;
    end else begin
      if (out_hs_c && out_single_err_o && (corr_cnt_o != '1))
        corr_cnt_o <= corr_cnt_o + CntWidth'(1);
      if (out_hs_c && out_double_err_o && (uncorr_cnt_o != '1))
        uncorr_cnt_o <= uncorr_cnt_o + CntWidth'(1);
    end
  end

endmodule

// File: tb/tb_ecc_decode_pipe.sv
// Self-checking bench for ecc_decode_pipe (DataWidth=8, CntWidth=2) with a scoreboard model.
`timescale 1ns/1ps

module tb_ecc_decode_pipe;

  localparam int DW   = 8;
  localparam int CWW  = 13;
  localparam int NPOS = 12;
  localparam int CMAX = 3;
`ifdef ECC_DECODE_PIPE_BYPASS_EN
  localparam int LAT = 1;
  localparam int CAP = 1;
`else
  localparam int LAT = 2;
  localparam int CAP = 2;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] syn;
    logic       single;
    logic       dbl;
  } exp_t;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           in_valid_i;
  logic           in_ready_o;
  logic [CWW-1:0] in_cw_i;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [DW-1:0]  out_data_o;
  logic [3:0]     out_syndrome_o;
  logic           out_single_err_o;
  logic           out_double_err_o;
  logic           clear_cnt_i;
  logic [1:0]     corr_cnt_o;
  logic [1:0]     uncorr_cnt_o;

  ecc_decode_pipe #(.DataWidth(8), .CntWidth(2)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .in_cw_i          (in_cw_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_data_o       (out_data_o),
    .out_syndrome_o   (out_syndrome_o),
    .out_single_err_o (out_single_err_o),
    .out_double_err_o (out_double_err_o),
    .clear_cnt_i      (clear_cnt_i),
    .corr_cnt_o       (corr_cnt_o),
    .uncorr_cnt_o     (uncorr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  exp_t sb[$];
  exp_t cur_exp;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   corr_m   = 0;
  int   uncorr_m = 0;
  int   accepted = 0;
  logic acc_flag = 1'b0;

  // Decode by definition: syndrome is the XOR of the indices of all set bits.
  function automatic exp_t model(logic [CWW-1:0] cw);
    exp_t           e;
    int             s;
    int             ones;
    int             j;
    logic [CWW-1:0] c;
    s    = 0;
    ones = 0;
    for (int i = 0; i < CWW; i++) begin
      if (cw[i]) begin
        ones++;
        if (i > 0) s = s ^ i;
      end
    end
    c        = cw;
    e.syn    = 4'(s);
    e.single = ((ones % 2) == 1) && (s <= NPOS);
    e.dbl    = ((ones % 2) == 1) ? (s > NPOS) : (s != 0);
    if (((ones % 2) == 1) && (s >= 1) && (s <= NPOS)) c[s] = ~c[s];
    j      = 0;
    e.data = '0;
    for (int pos = 1; pos <= NPOS; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        e.data[j] = c[pos];
        j++;
      end
    end
    return e;
  endfunction

  function automatic logic [CWW-1:0] encode(logic [DW-1:0] d);
    logic [CWW-1:0] c;
    int             j;
    int             x;
    c = '0;
    j = 0;
    x = 0;
    for (int pos = 1; pos <= NPOS; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[j];
        if (d[j]) x = x ^ pos;
        j++;
      end
    end
    for (int k = 0; k < 4; k++) c[1 << k] = x[k];
    c[0] = ^c[CWW-1:1];
    return c;
  endfunction

  // kind: 0 clean, 1 single flip, 2 double flip, 3 arbitrary word
  function automatic logic [CWW-1:0] rand_cw(int kind);
    logic [CWW-1:0] w;
    int             p1;
    int             p2;
    w  = encode(8'($urandom));
    p1 = int'($urandom_range(0, CWW - 1));
    p2 = (p1 + 1 + int'($urandom_range(0, CWW - 2))) % CWW;
    case (kind)
      1:       w[p1] = ~w[p1];
      2:       begin w[p1] = ~w[p1]; w[p2] = ~w[p2]; end
      3:       w = 13'($urandom);
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [CWW-1:0] w);
    in_valid_i = 1'b1;
    in_cw_i    = w;
    cur_exp    = model(w);
  endtask

  // One clock: check at the falling edge, update the model for the coming edge.
  task automatic step();
    exp_t e;
    @(negedge clk_i);
    chk("corr_cnt", 32'(corr_cnt_o), 32'(corr_m));
    chk("uncorr_cnt", 32'(uncorr_cnt_o), 32'(uncorr_m));
    if (out_valid_o) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid_o), 32'(0));
      end else begin
        e = sb[0];
        chk("out_data", 32'(out_data_o), 32'(e.data));
        chk("out_syndrome", 32'(out_syndrome_o), 32'(e.syn));
        chk("out_single_err", 32'(out_single_err_o), 32'(e.single));
        chk("out_double_err", 32'(out_double_err_o), 32'(e.dbl));
        if (out_ready_i) begin
          void'(sb.pop_front());
          if (e.single && corr_m < CMAX) corr_m++;
          if (e.dbl && uncorr_m < CMAX) uncorr_m++;
        end
      end
    end
    if (clear_cnt_i) begin
      corr_m   = 0;
      uncorr_m = 0;
    end
    acc_flag = in_valid_i && in_ready_o;
    if (acc_flag) begin
      sb.push_back(cur_exp);
      accepted++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    for (int k = 0; k < 40 && sb.size() != 0; k++) step();
    chk("drain_empty", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [CWW-1:0] dir_cw  [5];
  exp_t           dir_exp [5];
  logic [CWW-1:0] bw      [4];
  int             lat;
  int             idx;
  int             acc0;

  initial begin
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    in_cw_i     = '0;
    out_ready_i = 1'b1;
    clear_cnt_i = 1'b0;
    cur_exp     = '0;
    dir_cw[0] = 13'h1EEE; dir_exp[0] = '{data: 8'hFF, syn: 4'd0,  single: 1'b0, dbl: 1'b0};
    dir_cw[1] = 13'h1EEF; dir_exp[1] = '{data: 8'hFF, syn: 4'd0,  single: 1'b1, dbl: 1'b0};
    dir_cw[2] = 13'h0020; dir_exp[2] = '{data: 8'h00, syn: 4'd5,  single: 1'b1, dbl: 1'b0};
    dir_cw[3] = 13'h0028; dir_exp[3] = '{data: 8'h03, syn: 4'd6,  single: 1'b0, dbl: 1'b1};
    dir_cw[4] = 13'h1003; dir_exp[4] = '{data: 8'h80, syn: 4'd13, single: 1'b0, dbl: 1'b1};

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_out_valid", 32'(out_valid_o), 32'(0));
    chk("rst_out_data", 32'(out_data_o), 32'(0));
    chk("rst_syndrome", 32'(out_syndrome_o), 32'(0));
    chk("rst_flags", 32'({out_single_err_o, out_double_err_o}), 32'(0));
    chk("rst_counters", 32'({corr_cnt_o, uncorr_cnt_o}), 32'(0));
    chk("rst_in_ready", 32'(in_ready_o), 32'(1));
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("post_rst_in_ready", 32'(in_ready_o), 32'(1));

    // Directed vectors, first one also measures latency
    drive(dir_cw[0]);
    cur_exp = dir_exp[0];
    step();
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 10) begin
      step();
      lat++;
    end
    chk("latency", 32'(lat), 32'(LAT));
    drain();
    for (int v = 1; v < 5; v++) begin
      drive(dir_cw[v]);
      cur_exp = dir_exp[v];
      step();
    end
    drain();
    chk("directed_corr_cnt", 32'(corr_cnt_o), 32'(2));
    chk("directed_uncorr_cnt", 32'(uncorr_cnt_o), 32'(2));

    // Backpressure: 5 stalled cycles while offering 4 words
    bw[0] = rand_cw(1);
    bw[1] = rand_cw(2);
    bw[2] = rand_cw(1);
    bw[3] = rand_cw(2);
    idx  = 0;
    acc0 = accepted;
    out_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (idx < 4) drive(bw[idx]); else in_valid_i = 1'b0;
      step();
      if (acc_flag) idx++;
    end
    chk("bp_accepted", 32'(accepted - acc0), 32'(CAP));
    chk("bp_in_ready", 32'(in_ready_o), 32'(0));
    out_ready_i = 1'b1;
    for (int k = 0; k < 20 && idx < 4; k++) begin
      drive(bw[idx]);
      step();
      if (acc_flag) idx++;
    end
    chk("bp_all_accepted", 32'(idx), 32'(4));
    drain();

    // Asynchronous reset with the pipeline full
    out_ready_i = 1'b0;
    drive(rand_cw(1));
    for (int k = 0; k < 3; k++) begin
      step();
      if (acc_flag) drive(rand_cw(2));
    end
    chk("pre_reset_full", 32'(out_valid_o), 32'(1));
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid_o), 32'(0));
    chk("async_rst_corr", 32'(corr_cnt_o), 32'(0));
    chk("async_rst_uncorr", 32'(uncorr_cnt_o), 32'(0));
    sb.delete();
    corr_m     = 0;
    uncorr_m   = 0;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("post_flush_in_ready", 32'(in_ready_o), 32'(1));
    chk("post_flush_out_valid", 32'(out_valid_o), 32'(0));

    // Saturation, then clear racing a correctable handshake
    out_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(rand_cw(1));
      step();
    end
    drain();
    chk("sat_corr_cnt", 32'(corr_cnt_o), 32'(3));
    drive(rand_cw(1));
    cur_exp.single = 1'b1;
    cur_exp = model(in_cw_i);
    step();
    in_valid_i = 1'b0;
    for (int k = 0; k < 10 && !out_valid_o; k++) step();
    clear_cnt_i = 1'b1;
    step();
    clear_cnt_i = 1'b0;
    chk("clear_vs_inc", 32'(corr_cnt_o), 32'(0));
    drain();

    // Randomized traffic with random stalls and clears
    in_valid_i = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!in_valid_i || acc_flag) begin
        if ($urandom_range(0, 3) != 0) drive(rand_cw(int'($urandom_range(0, 3))));
        else in_valid_i = 1'b0;
      end
      out_ready_i = ($urandom_range(0, 3) != 0);
      clear_cnt_i = ($urandom_range(0, 19) == 0);
      step();
    end
    clear_cnt_i = 1'b0;
    drain();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
